// File: rtl/data_mem_waitstate.sv
// MEM-stage data memory: RV32I byte/half/word loads and stores, optional wait
// states signalled through MemStall, and an error pulse for misaligned or illegal ops.
module data_mem_waitstate #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MemOp,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] MemReadDataOut,
  output logic        MemStall,
  output logic        MemErr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req_in, active, is_st, is_ld, misalign, illegal, err, we;
  logic [2:0]  e_op;
  logic [31:0] e_addr, e_wdata, word, shifted, ld_val, wd;
  logic        e_rd, e_wr;
  logic [3:0]  be;
  logic [15:0] half;
  logic [AW-1:0] idx;
  logic        unused_addr;

  assign req_in = MemRead | MemWrite;

  // While BUSY the captured request drives the access; the ports are ignored.
  always_comb begin
    e_op    = MemOp;
    e_addr  = DataAddr;
    e_wdata = WriteData;
    e_rd    = MemRead;
    e_wr    = MemWrite;
    if (state_q == BUSY) begin
      e_op    = op_q;
      e_addr  = addr_q;
      e_wdata = wdata_q;
      e_rd    = rd_q;
      e_wr    = wr_q;
    end
  end

  assign idx         = e_addr[AW+1:2];
  assign unused_addr = ^{e_addr[31:AW+2]};
  assign word        = mem[idx];

  assign active   = reset && (((state_q == IDLE) && (LATENCY == 0) && req_in) ||
                              ((state_q == BUSY) && (cnt_q == 3'd0)));
  assign MemStall = reset && (((state_q == IDLE) && (LATENCY != 0) && req_in) ||
                              ((state_q == BUSY) && (cnt_q != 3'd0)));

  assign is_st = e_wr;
  assign is_ld = e_rd & ~e_wr;

  always_comb begin
    misalign = 1'b0;
    case (e_op[1:0])
      2'b01:   misalign = e_addr[0];
      2'b10:   misalign = (e_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  assign illegal = is_st ? (e_op > 3'b010)
                         : ((e_op == 3'b011) || (e_op[2:1] == 2'b11));
  assign err     = active & (misalign | illegal);
  assign MemErr  = err;

  assign shifted = word >> {e_addr[1:0], 3'b000};
  assign half    = e_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_val = 32'd0;
    case (e_op)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_val = {24'd0, shifted[7:0]};
      3'b001:  ld_val = {{16{half[15]}}, half};
      3'b101:  ld_val = {16'd0, half};
      3'b010:  ld_val = word;
      default: ld_val = 32'd0;
    endcase
  end

  assign MemReadDataOut = (active & is_ld & ~err) ? ld_val : 32'd0;

  always_comb begin
    be = 4'b1111;
    wd = e_wdata;
    case (e_op[1:0])
      2'b00: begin
        be = 4'b0001 << e_addr[1:0];
        wd = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        be = e_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{e_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = e_wdata;
      end
    endcase
  end

  // Gated by reset so an access interrupted by reset can never commit.
  assign we = active & is_st & ~err;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if ((LATENCY != 0) && req_in) begin
          op_q    <= MemOp;
          addr_q  <= DataAddr;
          wdata_q <= WriteData;
          rd_q    <= MemRead;
          wr_q    <= MemWrite;
          cnt_q   <= CNT_INIT;
          state_q <= BUSY;
        end
        BUSY: if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
              else               state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_waitstate.sv
// Bench for data_mem_waitstate: three instances (0, 3 and 4 wait states) checked
// against a scoreboard of expected load data / error flags and stall counts.
module tb_data_mem_waitstate;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  op    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        err   [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  data_mem_waitstate #(.DEPTH_WORDS(1024), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .MemOp(op[0]), .DataAddr(addr[0]), .WriteData(wd[0]),
    .MemRead(rd[0]), .MemWrite(wr[0]), .MemReadDataOut(rdata[0]), .MemStall(stall[0]),
    .MemErr(err[0]));
  data_mem_waitstate #(.DEPTH_WORDS(1024), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .MemOp(op[1]), .DataAddr(addr[1]), .WriteData(wd[1]),
    .MemRead(rd[1]), .MemWrite(wr[1]), .MemReadDataOut(rdata[1]), .MemStall(stall[1]),
    .MemErr(err[1]));
  data_mem_waitstate #(.DEPTH_WORDS(1024), .LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .MemOp(op[2]), .DataAddr(addr[2]), .WriteData(wd[2]),
    .MemRead(rd[2]), .MemWrite(wr[2]), .MemReadDataOut(rdata[2]), .MemStall(stall[2]),
    .MemErr(err[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic drive(input int k, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] w, input logic r, input logic ww);
    op[k] = o; addr[k] = a; wd[k] = w; rd[k] = r; wr[k] = ww;
  endtask

  task automatic clear(input int k);
    drive(k, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // One access: expectation queued at issue, popped and compared at completion.
  // Instances with wait states see random garbage on the ports while busy.
  task automatic access(input int k, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] w, input logic r, input logic ww,
                        input logic [31:0] expd, input logic expe, input string nm);
    exp_t x;
    int   n;
    bit   done;
    x.d = expd;
    x.e = expe;
    @(posedge clk); #1;
    drive(k, o, a, w, r, ww);
    sb.push_back(x);
    n = 0;
    done = 0;
    while (!done) begin
      #3;
      if (stall[k] === 1'b0) begin
        x = sb.pop_front();
        checks++;
        if (rdata[k] !== x.d) begin
          errors++;
          $display("FAIL %s data: got %h want %h", nm, rdata[k], x.d);
        end
        checks++;
        if (err[k] !== x.e) begin
          errors++;
          $display("FAIL %s err: got %b want %b", nm, err[k], x.e);
        end
        checks++;
        if (n != lat_of(k)) begin
          errors++;
          $display("FAIL %s stall cycles: got %0d want %0d", nm, n, lat_of(k));
        end
        if (k != 0) clear(k);
        done = 1;
      end else if (n >= 12) begin
        x = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s timeout: stall stuck at %b", nm, stall[k]);
        clear(k);
        done = 1;
      end else begin
        n++;
        @(posedge clk); #1;
        if (k != 0)
          drive(k, 3'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      end
    end
  endtask

  task automatic idle_check(input int k, input string nm);
    @(posedge clk); #1;
    clear(k);
    @(posedge clk); #3;
    checks++;
    if (stall[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'd0) begin
      errors++;
      $display("FAIL %s idle: stall %b err %b data %h, want 0 0 0", nm, stall[k], err[k], rdata[k]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0);
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'd0) begin
        errors++;
        $display("FAIL reset inst%0d: stall %b err %b data %h, want 0 0 0", k, stall[k], err[k], rdata[k]);
      end
    end
    for (int k = 0; k < 3; k++) clear(k);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_cycle;
    access(0, 3'b010, 32'h10, 32'h8000_00F1, 1'b0, 1'b1, 32'h0, 1'b0, "sw");
    access(0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h8000_00F1, 1'b0, "lw");
    access(0, 3'b000, 32'h10, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFF1, 1'b0, "lb");
    access(0, 3'b100, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0000_00F1, 1'b0, "lbu");
    access(0, 3'b001, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFF_8000, 1'b0, "lh");
    access(0, 3'b101, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000_8000, 1'b0, "lhu");
    idle_check(0, "l0");
  endtask

  task automatic test_byte_store;
    access(0, 3'b010, 32'h10, 32'h1122_3344, 1'b0, 1'b1, 32'h0, 1'b0, "sw2");
    access(0, 3'b000, 32'h11, 32'h0000_00AB, 1'b0, 1'b1, 32'h0, 1'b0, "sb");
    access(0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h1122_AB44, 1'b0, "lw_sb");
    access(0, 3'b001, 32'h10, 32'h0, 1'b1, 1'b0, 32'hFFFF_AB44, 1'b0, "lh_lo");
    access(0, 3'b010, 32'h1010, 32'h0, 1'b1, 1'b0, 32'h1122_AB44, 1'b0, "alias");
    access(0, 3'b001, 32'h12, 32'h0000_5566, 1'b0, 1'b1, 32'h0, 1'b0, "sh");
    access(0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h5566_AB44, 1'b0, "lw_sh");
    access(0, 3'b010, 32'h14, 32'h0BAD_F00D, 1'b1, 1'b1, 32'h0, 1'b0, "rdwr");
    access(0, 3'b010, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, "lw_rdwr");
  endtask

  task automatic test_errors;
    access(0, 3'b010, 32'h12, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b1, "sw_mis");
    access(0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h5566_AB44, 1'b0, "lw_after_mis");
    access(0, 3'b001, 32'h13, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, "lh_mis");
    access(0, 3'b111, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, "op111");
    access(0, 3'b100, 32'h14, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b1, "st_op100");
    access(0, 3'b010, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, "lw_after_ill");
    idle_check(0, "err_pulse");
  endtask

  task automatic test_wait_states;
    access(1, 3'b010, 32'h40, 32'hCAFE_BABE, 1'b0, 1'b1, 32'h0, 1'b0, "l3_sw");
    access(1, 3'b010, 32'h40, 32'h0, 1'b1, 1'b0, 32'hCAFE_BABE, 1'b0, "l3_lw");
    access(1, 3'b001, 32'h41, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, "l3_mis");
    idle_check(1, "l3");
  endtask

  task automatic test_back_to_back;
    access(1, 3'b100, 32'h43, 32'h0, 1'b1, 1'b0, 32'h0000_00CA, 1'b0, "b2b_lbu");
    access(1, 3'b001, 32'h40, 32'h0, 1'b1, 1'b0, 32'hFFFF_BABE, 1'b0, "b2b_lh");
    access(1, 3'b101, 32'h42, 32'h0, 1'b1, 1'b0, 32'h0000_CAFE, 1'b0, "b2b_lhu");
  endtask

  task automatic test_reset_abort;
    access(2, 3'b010, 32'h20, 32'h1111_1111, 1'b0, 1'b1, 32'h0, 1'b0, "l4_sw");
    @(posedge clk); #1;
    drive(2, 3'b010, 32'h20, 32'h2222_2222, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (stall[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 32'd0) begin
      errors++;
      $display("FAIL abort outputs: stall %b err %b data %h, want 0 0 0", stall[2], err[2], rdata[2]);
    end
    clear(2);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    access(2, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, "abort_lw");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) clear(k);
    test_reset();
    test_single_cycle();
    test_byte_store();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
